uc_multicycle: RTL and testbench
================================

UC_MULTICYCLE -- requirements
Module: uc_multicycle

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16: maximum cycles a memory access may wait for mem_ready before a bus error.
REQ-002 SHALL have parameter CNT_W, default 64: width of the retired-instruction counter.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port opcode, input, 7 bits: the IR opcode field from the datapath.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory has completed the current read or write this cycle.
REQ-007 SHALL have port mem_req, output, 1 bit: a memory access is in progress.
REQ-008 SHALL have ports WE_RF, WE_MEM, load_pc, load_ir, addr_sel, ULA_din2_sel, pc_next_sel and pc_adder_sel, each output, 1 bit: datapath strobes and selects.
REQ-009 SHALL have port RF_din_sel, output, 2 bits: 00 DM_out, 01 ALU, 10 pc+4 (primary adder), 11 secondary adder.
REQ-010 SHALL have port state, output, 3 bits, with encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.
REQ-011 SHALL have ports halted, illegal and bus_error, each output, 1 bit: sticky status flags.
REQ-012 SHALL have port instret, output, CNT_W bits: count of retired instructions.

Function
REQ-013 SHALL drive every output not listed for a state to 0 in that state.
REQ-014 In FETCH, SHALL assert mem_req=1 and addr_sel=1.
REQ-015 In FETCH, when mem_ready=1, SHALL also assert load_ir=1 and move to DECODE.
REQ-016 DECODE SHALL last exactly 1 cycle (regfile read and immediate decode), drive no strobes, and move to EXEC.
REQ-017 In EXEC, for opcodes 0110011 and 0111011 (R-type), SHALL assert WE_RF=1, RF_din_sel=01, ULA_din2_sel=0 and load_pc=1, then move to FETCH.
REQ-018 In EXEC, for opcodes 0010011, 0011011 and 0110111 (I-type ALU and LUI), SHALL drive the same outputs as REQ-017 but with ULA_din2_sel=1.
REQ-019 In EXEC, for opcode 0010111 (AUIPC), SHALL assert WE_RF=1, RF_din_sel=11, pc_adder_sel=0 and load_pc=1, then move to FETCH.
REQ-020 In EXEC, for opcode 1100011 (branch), SHALL assert load_pc=1, pc_next_sel=1 and pc_adder_sel=0, leave the taken/not-taken decision to the PC block, and move to FETCH.
REQ-021 In EXEC, for opcode 1101111 (JAL), SHALL assert WE_RF=1, RF_din_sel=10, load_pc=1, pc_next_sel=1 and pc_adder_sel=0, then move to FETCH.
REQ-022 In EXEC, for opcode 1100111 (JALR), SHALL drive the same outputs as REQ-021 but with pc_adder_sel=1.
REQ-023 In EXEC, for opcodes 0000011 (load) and 0100011 (store), SHALL assert ULA_din2_sel=1 and move to MEM.
REQ-024 In EXEC, for opcode 1110011 (SYSTEM), SHALL move to HALT and set halted=1.
REQ-025 In EXEC, for any other opcode, SHALL move to HALT and set halted=1 and illegal=1; instret SHALL NOT increment.
REQ-026 In MEM, SHALL assert mem_req=1, addr_sel=0 and ULA_din2_sel=1, and SHALL assert WE_MEM=1 throughout for a store.
REQ-027 In MEM, when mem_ready=1 on a load, SHALL assert WE_RF=1, RF_din_sel=00 and load_pc=1, then move to FETCH.
REQ-028 In MEM, when mem_ready=1 on a store, SHALL assert load_pc=1, then move to FETCH.
REQ-029 SHALL latch the load/store kind on EXEC exit so MEM behaviour does not depend on opcode changing.
REQ-030 A wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle with mem_req=1 and mem_ready=0.
REQ-031 When the wait counter reaches WAIT_LIMIT, the block SHALL move to HALT and set halted=1 and bus_error=1, with no strobe asserted in that cycle.
REQ-032 SHALL increment instret by 1 in every cycle in which load_pc=1; instret SHALL wrap from all-ones to 0.
REQ-033 HALT SHALL be absorbing: all strobes 0 and flags held until reset.
REQ-034 mem_ready=1 outside FETCH or MEM SHALL be ignored.
REQ-035 WE_RF, WE_MEM, load_pc and load_ir SHALL never be asserted in DECODE or HALT.

Reset
REQ-036 reset=1 SHALL immediately, without waiting for CLK, force state=FETCH, clear all strobes, the wait counter, instret, halted, illegal, bus_error and the latched load/store kind.
REQ-037 A reset asserted in the middle of an operation SHALL abort the in-flight access with no write strobe leaking; the first cycle after reset release SHALL be FETCH with mem_req=1.

Verification
REQ-038 ADDI (opcode 0010011) with mem_ready=1 immediately -> states 0,1,2,0; in EXEC WE_RF=1, RF_din_sel=01, ULA_din2_sel=1, load_pc=1; instret=1.
REQ-039 Load (opcode 0000011) with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles; WE_RF and load_pc pulse only on the ready cycle; WE_MEM stays 0.
REQ-040 Store (opcode 0100011) -> WE_MEM=1 for every MEM cycle, WE_RF stays 0, load_pc=1 on the ready cycle.
REQ-041 JALR (opcode 1100111) -> EXEC drives RF_din_sel=10, pc_next_sel=1, pc_adder_sel=1; opcode 1111111 -> HALT with illegal=1, instret unchanged.
REQ-042 mem_ready held 0 in FETCH with WAIT_LIMIT=16 -> HALT after 16 cycles with bus_error=1.
REQ-043 reset pulsed mid-MEM on a store -> WE_MEM drops in the same cycle, state=0, instret=0.

Source files
------------

// File: rtl/uc_multicycle.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM for a RISC-V style
// datapath, handles memory wait states with a bus-error timeout, and keeps
// sticky halt/illegal/bus-error flags plus a retired-instruction counter.
module uc_multicycle #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 64
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             WE_RF,
  output logic             WE_MEM,
  output logic             load_pc,
  output logic             load_ir,
  output logic             addr_sel,
  output logic             ULA_din2_sel,
  output logic             pc_next_sel,
  output logic             pc_adder_sel,
  output logic [1:0]       RF_din_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_R, OP_I, OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR,
    OP_LOAD, OP_STORE, OP_SYSTEM, OP_ILLEGAL
  } op_class_t;

  state_t          state_q, state_d;
  op_class_t       op_class;
  logic [WAIT_W-1:0] wait_cnt;
  logic            is_store;
  logic            wait_expired;

  assign state = state_q;

  // A memory wait that would be the WAIT_LIMIT-th stalled cycle ends the access.
  assign wait_expired = (state_q == FETCH || state_q == MEM) && !mem_ready &&
                        (wait_cnt == WAIT_W'(WAIT_LIMIT - 1));

  // Opcode decode into instruction classes.
  always_comb begin
    case (opcode)
      7'b0110011, 7'b0111011:             op_class = OP_R;
      7'b0010011, 7'b0011011, 7'b0110111: op_class = OP_I;
      7'b0010111:                         op_class = OP_AUIPC;
      7'b1100011:                         op_class = OP_BRANCH;
      7'b1101111:                         op_class = OP_JAL;
      7'b1100111:                         op_class = OP_JALR;
      7'b0000011:                         op_class = OP_LOAD;
      7'b0100011:                         op_class = OP_STORE;
      7'b1110011:                         op_class = OP_SYSTEM;
      default:                            op_class = OP_ILLEGAL;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every comb output first prevents latch inference on
    // paths that do not assign it.
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (mem_ready)         state_d = DECODE;
        else if (wait_expired) state_d = HALT;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        case (op_class)
          OP_LOAD, OP_STORE:     state_d = MEM;
          OP_SYSTEM, OP_ILLEGAL: state_d = HALT;
          default:               state_d = FETCH;
        endcase
      end
      MEM: begin
        if (mem_ready)         state_d = FETCH;
        else if (wait_expired) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Output decode; reset forces every strobe low without waiting for a clock.
  always_comb begin
    mem_req      = 1'b0;
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    load_pc      = 1'b0;
    load_ir      = 1'b0;
    addr_sel     = 1'b0;
    ULA_din2_sel = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    RF_din_sel   = 2'b00;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          load_ir  = mem_ready;
        end
        EXEC: begin
          case (op_class)
            OP_R: begin
              WE_RF = 1'b1; RF_din_sel = 2'b01; load_pc = 1'b1;
            end
            OP_I: begin
              WE_RF = 1'b1; RF_din_sel = 2'b01; load_pc = 1'b1; ULA_din2_sel = 1'b1;
            end
            OP_AUIPC: begin
              WE_RF = 1'b1; RF_din_sel = 2'b11; load_pc = 1'b1;
            end
            OP_BRANCH: begin
              load_pc = 1'b1; pc_next_sel = 1'b1;
            end
            OP_JAL: begin
              WE_RF = 1'b1; RF_din_sel = 2'b10; load_pc = 1'b1; pc_next_sel = 1'b1;
            end
            OP_JALR: begin
              WE_RF = 1'b1; RF_din_sel = 2'b10; load_pc = 1'b1; pc_next_sel = 1'b1;
              pc_adder_sel = 1'b1;
            end
            OP_LOAD, OP_STORE: ULA_din2_sel = 1'b1;
            default: ;
          endcase
        end
        MEM: begin
          mem_req      = 1'b1;
          ULA_din2_sel = 1'b1;
          // The timeout cycle must not leave a write strobe on the bus.
          WE_MEM       = is_store && !wait_expired;
          if (mem_ready) begin
            load_pc = 1'b1;
            WE_RF   = !is_store;
          end
        end
        default: ;
      endcase
    end
  end

  // Wait counter, latched access kind, sticky flags and retired count.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      is_store  <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
      instret   <= '0;
    end else begin
      // Any state change clears the counter, which covers entry to FETCH/MEM.
      if (state_d != state_q)
        wait_cnt <= '0;
      else if ((state_q == FETCH || state_q == MEM) && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);

      if (state_q == EXEC && state_d == MEM)
        is_store <= (op_class == OP_STORE);

      if (state_q != HALT && state_d == HALT) halted <= 1'b1;
      if (state_q == EXEC && op_class == OP_ILLEGAL) illegal <= 1'b1;
      if (wait_expired) bus_error <= 1'b1;

      if (load_pc) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uc_multicycle.sv
// Scoreboard bench for uc_multicycle: the driver walks random instructions
// through the control unit and queues the expected retirement/halt event; a
// monitor on the falling edge pops and compares whenever the DUT retires
// (load_pc) or enters HALT.
module tb_uc_multicycle;

  localparam int WAIT_LIMIT = 16;
  localparam int CNT_W      = 64;

  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic             CLK;
  logic             reset;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             mem_req, WE_RF, WE_MEM, load_pc, load_ir, addr_sel;
  logic             ULA_din2_sel, pc_next_sel, pc_adder_sel;
  logic [1:0]       RF_din_sel;
  logic [2:0]       state;
  logic             halted, illegal, bus_error;
  logic [CNT_W-1:0] instret;

  uc_multicycle #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .WE_RF(WE_RF), .WE_MEM(WE_MEM), .load_pc(load_pc),
    .load_ir(load_ir), .addr_sel(addr_sel), .ULA_din2_sel(ULA_din2_sel),
    .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel),
    .RF_din_sel(RF_din_sel), .state(state), .halted(halted),
    .illegal(illegal), .bus_error(bus_error), .instret(instret)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit         is_halt;
    logic [9:0] outs;      // outputs expected in the retirement cycle
    int         cycles;    // cycles from FETCH start to the event, inclusive
    int         we_mem_cnt;
    int         we_rf_cnt;
    int         load_ir_cnt;
    logic [63:0] instret;
    logic [2:0] flags;     // {halted, illegal, bus_error}
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] model_cnt = 0;
  logic [6:0]  ret_ops [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {mem_req, addr_sel, WE_RF, WE_MEM, load_ir, ULA_din2_sel, pc_next_sel, pc_adder_sel, RF_din_sel}
  function automatic logic [9:0] pack_outs();
    return {mem_req, addr_sel, WE_RF, WE_MEM, load_ir, ULA_din2_sel,
            pc_next_sel, pc_adder_sel, RF_din_sel};
  endfunction

  // Reference table: outputs seen in the cycle an instruction retires.
  function automatic logic [9:0] model_outs(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0111011:             return 10'b0_0_1_0_0_0_0_0_01;
      7'b0010011, 7'b0011011, 7'b0110111: return 10'b0_0_1_0_0_1_0_0_01;
      7'b0010111:                         return 10'b0_0_1_0_0_0_0_0_11;
      7'b1100011:                         return 10'b0_0_0_0_0_0_1_0_00;
      7'b1101111:                         return 10'b0_0_1_0_0_0_1_0_10;
      7'b1100111:                         return 10'b0_0_1_0_0_0_1_1_10;
      7'b0000011:                         return 10'b1_0_1_0_0_1_0_0_00;
      7'b0100011:                         return 10'b1_0_0_1_0_1_0_0_00;
      default:                            return 10'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Fetch with fw stalled cycles; returns with the DUT in DECODE.
  task automatic drive_fetch(input int fw);
    opcode = 7'($urandom);
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0;
      step();
    end
    mem_ready = 1'b1;
    step();
  endtask

  // Retiring instruction; mw < 0 on a load means memory never answers.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    exp_t e;
    bit   is_mem;
    is_mem        = (op == OP_LOAD) || (op == OP_STORE);
    e.is_halt     = 1'b0;
    e.outs        = model_outs(op);
    e.cycles      = fw + 3 + (is_mem ? mw + 1 : 0);
    e.we_mem_cnt  = (op == OP_STORE) ? mw + 1 : 0;
    e.we_rf_cnt   = int'(e.outs[7]);
    e.load_ir_cnt = 1;
    e.instret     = model_cnt;
    e.flags       = 3'b000;
    if (is_mem && mw < 0) begin
      e.is_halt    = 1'b1;
      e.cycles     = fw + WAIT_LIMIT + 4;
      e.we_mem_cnt = 0;
      e.we_rf_cnt  = 0;
      e.flags      = 3'b101;
    end else begin
      model_cnt = model_cnt + 1;
    end
    sb.push_back(e);

    drive_fetch(fw);
    opcode = op; mem_ready = 1'($urandom_range(0, 1));
    step();                                   // EXEC
    mem_ready = 1'($urandom_range(0, 1));
    step();                                   // left EXEC
    if (is_mem) begin
      if (mw < 0) begin
        mem_ready = 1'b0;
        repeat (WAIT_LIMIT + 3) step();
      end else begin
        for (int i = 0; i < mw; i++) begin
          opcode = 7'($urandom); mem_ready = 1'b0;
          step();
        end
        opcode = 7'($urandom); mem_ready = 1'b1;
        step();
      end
    end
    mem_ready = 1'b0;
  endtask

  // SYSTEM or unknown opcode: expect HALT right after EXEC.
  task automatic run_halt(input logic [6:0] op, input int fw, input logic [2:0] flags);
    exp_t e;
    e.is_halt = 1'b1; e.outs = '0; e.cycles = fw + 4; e.we_mem_cnt = 0;
    e.we_rf_cnt = 0; e.load_ir_cnt = 1; e.instret = model_cnt; e.flags = flags;
    sb.push_back(e);
    drive_fetch(fw);
    opcode = op; mem_ready = 1'($urandom_range(0, 1));
    step();
    repeat (5) begin
      mem_ready = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic do_reset();
    check("sb_drained", 64'(sb.size()), 64'd0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    model_cnt = 0;
  endtask

  // Monitor: count strobes since the last event, compare on each event.
  int         mon_cyc, mon_wm, mon_wr, mon_ir;
  bit         mon_in_halt;
  logic [2:0] mon_flags;
  exp_t       mon_e;

  always @(negedge CLK) begin
    if (reset) begin
      mon_cyc = 0; mon_wm = 0; mon_wr = 0; mon_ir = 0; mon_in_halt = 1'b0;
    end else begin
      mon_cyc++;
      mon_wm += int'(WE_MEM);
      mon_wr += int'(WE_RF);
      mon_ir += int'(load_ir);
      if (load_pc || (state == 3'd4 && !mon_in_halt)) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_event: DUT event in state %0d with nothing expected", state);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind", 64'(!load_pc), 64'(mon_e.is_halt));
          if (!mon_e.is_halt) check("retire_outs", 64'(pack_outs()), 64'(mon_e.outs));
          else                check("halt_flags", 64'({halted, illegal, bus_error}), 64'(mon_e.flags));
          check("latency", 64'(mon_cyc), 64'(mon_e.cycles));
          check("strobe_counts", 64'({8'(mon_wm), 8'(mon_wr), 8'(mon_ir)}),
                64'({8'(mon_e.we_mem_cnt), 8'(mon_e.we_rf_cnt), 8'(mon_e.load_ir_cnt)}));
          check("instret", instret, mon_e.instret);
          mon_flags = mon_e.flags;
        end
        if (!load_pc) mon_in_halt = 1'b1;
        mon_cyc = 0; mon_wm = 0; mon_wr = 0; mon_ir = 0;
      end else if (mon_in_halt) begin
        check("halt_quiet", 64'({pack_outs(), load_pc}), 64'd0);
        check("halt_hold", 64'({halted, illegal, bus_error}), 64'(mon_flags));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ret_ops = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0110111,
                7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0000011,
                7'b0100011};
    reset = 1'b1; opcode = OP_ADDI; mem_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #3;
    check("rst_state", 64'(state), 64'd0);
    check("rst_strobes", 64'({WE_RF, WE_MEM, load_pc, load_ir}), 64'd0);
    check("rst_flags", 64'({halted, illegal, bus_error}), 64'd0);
    check("rst_instret", instret, 64'd0);
    step();
    reset = 1'b0;

    // Directed scenarios, then random legal instructions.
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_LOAD, 1, 3);
    run_instr(OP_STORE, 0, 2);
    run_instr(OP_JALR, 2, 0);
    repeat (60) run_instr(ret_ops[$urandom_range(0, 10)], $urandom_range(0, 4), $urandom_range(0, 4));
    run_halt(OP_BAD, 1, 3'b110);

    do_reset();
    run_instr(OP_ADDI, 0, 0);
    run_halt(OP_SYS, 0, 3'b100);

    // Fetch that never completes.
    do_reset();
    begin
      exp_t e;
      e.is_halt = 1'b1; e.outs = '0; e.cycles = WAIT_LIMIT + 1; e.we_mem_cnt = 0;
      e.we_rf_cnt = 0; e.load_ir_cnt = 0; e.instret = 64'd0; e.flags = 3'b101;
      sb.push_back(e);
      mem_ready = 1'b0;
      repeat (WAIT_LIMIT + 4) step();
    end

    // Load whose data phase never completes.
    do_reset();
    run_instr(OP_ADDI, 1, 0);
    run_instr(OP_LOAD, 0, -1);

    // Reset in the middle of a stalled store.
    do_reset();
    run_instr(OP_ADDI, 0, 0);
    drive_fetch(0);
    opcode = OP_STORE; step();
    step();
    mem_ready = 1'b0; step();
    check("store_mid_we_mem", 64'(WE_MEM), 64'd1);
    check("store_mid_state", 64'(state), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("abort_we_mem", 64'(WE_MEM), 64'd0);
    check("abort_state", 64'(state), 64'd0);
    check("abort_instret", instret, 64'd0);
    step(); step();
    reset = 1'b0; model_cnt = 0;
    #1;
    check("post_rst_fetch", 64'({state, mem_req}), 64'({3'd0, 1'b1}));
    run_instr(OP_ADDI, 0, 0);
    step(); step();
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
